// File: rtl/key_debounce_ctrl_if.sv
// Bundle for the four raw push-buttons and the control registers they drive.
interface key_debounce_ctrl_if;
    logic [3:0] key;
    logic [3:0] key_flag;
    logic [1:0] waveform_counter;
    logic [4:0] freq_counter;
    logic [4:0] freq_counter2;

    modport master (
        output key,
        input  key_flag,
        input  waveform_counter,
        input  freq_counter,
        input  freq_counter2
    );

    modport slave (
        input  key,
        output key_flag,
        output waveform_counter,
        output freq_counter,
        output freq_counter2
    );
endinterface

// File: rtl/key_debounce_ctrl.sv
// Four-key debouncer: per-key synchronizer and stable-count filter, a one-cycle
// press pulse per key, and the waveform / frequency step registers it drives.
module key_debounce_ctrl #(
    parameter int CNT_MAX   = 999_999,
    parameter int FREQ_MAX  = 31,
    parameter int FREQ_INIT = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    key_debounce_ctrl_if.slave bus
);

    localparam int              CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);
    localparam logic [4:0]      FREQ_TOP  = 5'(FREQ_MAX);
    localparam logic [4:0]      FREQ_RST  = 5'(FREQ_INIT);

    logic [3:0]       key_p0;
    logic [3:0]       key_p1;
    logic [CNT_W-1:0] cnt_p2 [4];
    logic [3:0]       db_p2;
    logic [3:0]       db_p3;
    logic [3:0]       flag_p3;
    logic [1:0]       wave_p4;
    logic [4:0]       freq_p4;
    logic [4:0]       freq2_p4;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= FREQ_TOP) ? v : v + 5'd1;
    endfunction

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v == 5'd0) ? v : v - 5'd1;
    endfunction

    function automatic logic [4:0] freq_step(input logic [4:0] v, input logic up, input logic down);
        logic [4:0] r;
        r = v;
        if (up && !down) begin
            r = sat_inc(v);
        end else if (down && !up) begin
            r = sat_dec(v);
        end
        return r;
    endfunction

    // Stage p0/p1: two-flop synchronizer; idle level is released (1).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_p0 <= 4'hF;
            key_p1 <= 4'hF;
        end else begin
            key_p0 <= bus.key;
            key_p1 <= key_p0;
        end
    end

    // Stage p2: independent stable-count filter per key. The state flips only
    // on the (CNT_MAX+1)-th consecutive cycle that the synchronized level differs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_p2[i] <= '0;
            end
            db_p2 <= 4'hF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_p1[i] == db_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LIMIT) begin
                    db_p2[i]  <= key_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage p3: press pulse on a debounced 1->0 transition only.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            db_p3   <= 4'hF;
            flag_p3 <= 4'h0;
        end else begin
            db_p3   <= db_p2;
            flag_p3 <= db_p3 & ~db_p2;
        end
    end

    // Stage p4: control registers act on the edge that ends the pulse cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wave_p4  <= 2'd0;
            freq_p4  <= FREQ_RST;
            freq2_p4 <= 5'd0;
        end else begin
            if (flag_p3[0]) begin
                wave_p4 <= wave_p4 + 2'd1;
            end
            freq_p4 <= freq_step(freq_p4, flag_p3[1], flag_p3[2]);
            if (flag_p3[3]) begin
                freq2_p4 <= freq2_p4 + 5'd1;
            end
        end
    end

    assign bus.key_flag         = flag_p3;
    assign bus.waveform_counter = wave_p4;
    assign bus.freq_counter     = freq_p4;
    assign bus.freq_counter2    = freq2_p4;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Bench for key_debounce_ctrl: behavioural model compared every cycle, plus
// literal expectations at the key timing points and counter boundaries.
module tb_key_debounce_ctrl;

    localparam int CNT_MAX   = 3;
    localparam int FREQ_MAX  = 5;
    localparam int FREQ_INIT = 0;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    key_debounce_ctrl_if bus ();

    key_debounce_ctrl #(
        .CNT_MAX  (CNT_MAX),
        .FREQ_MAX (FREQ_MAX),
        .FREQ_INIT(FREQ_INIT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a key's filtered level follows its input (seen two cycles late)
    // once it has disagreed for CNT_MAX+1 cycles in a row; a press shows as a
    // pulse one cycle after that, and the action lands one cycle after the pulse.
    logic [3:0] m_s1, m_s2, m_db, m_pend, m_flag;
    int         m_run [4];
    int         m_wave, m_freq, m_freq2;

    logic [3:0] db_n, pend_n;
    int         run_n [4];
    int         f_n;

    always_comb begin
        db_n   = m_db;
        pend_n = 4'h0;
        for (int i = 0; i < 4; i++) begin
            run_n[i] = (m_s2[i] != m_db[i]) ? m_run[i] + 1 : 0;
            if (run_n[i] == CNT_MAX + 1) begin
                db_n[i]   = m_s2[i];
                run_n[i]  = 0;
                pend_n[i] = ~m_s2[i];
            end
        end
        f_n = m_freq + (m_flag[1] ? 1 : 0) - (m_flag[2] ? 1 : 0);
        if (f_n > FREQ_MAX) f_n = FREQ_MAX;
        if (f_n < 0) f_n = 0;
    end

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_s1    <= 4'hF;
            m_s2    <= 4'hF;
            m_db    <= 4'hF;
            m_pend  <= 4'h0;
            m_flag  <= 4'h0;
            m_wave  <= 0;
            m_freq  <= FREQ_INIT;
            m_freq2 <= 0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else begin
            m_s1    <= bus.key;
            m_s2    <= m_s1;
            m_db    <= db_n;
            for (int i = 0; i < 4; i++) m_run[i] <= run_n[i];
            m_pend  <= pend_n;
            m_flag  <= m_pend;
            m_wave  <= (m_wave + (m_flag[0] ? 1 : 0)) % 4;
            m_freq  <= f_n;
            m_freq2 <= (m_freq2 + (m_flag[3] ? 1 : 0)) % 32;
        end
    end

    always @(negedge sys_clk) begin
        chk("key_flag", int'(bus.key_flag), int'(m_flag));
        chk("waveform_counter", int'(bus.waveform_counter), m_wave);
        chk("freq_counter", int'(bus.freq_counter), m_freq);
        chk("freq_counter2", int'(bus.freq_counter2), m_freq2);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic press(input int idx, input int hold, input int rel);
        bus.key[idx] = 1'b0;
        cycles(hold);
        bus.key[idx] = 1'b1;
        cycles(rel);
    endtask

    int exp_up [6]   = '{2, 3, 4, 5, 5, 5};
    int exp_dn [7]   = '{4, 3, 2, 1, 0, 0, 0};
    int exp_wave [3] = '{2, 3, 0};

    initial begin
        bus.key = 4'hF;
        cycles(3);
        chk("reset_flag", int'(bus.key_flag), 0);
        chk("reset_wave", int'(bus.waveform_counter), 0);
        chk("reset_freq", int'(bus.freq_counter), FREQ_INIT);
        chk("reset_freq2", int'(bus.freq_counter2), 0);
        sys_rst = 1'b0;
        cycles(2);

        // Clean key[0] press: pulse after edge 7, register after edge 8.
        bus.key[0] = 1'b0;
        cycles(6);
        chk("k0_flag_edge6", int'(bus.key_flag), 0);
        cycles(1);
        chk("k0_flag_edge7", int'(bus.key_flag), 1);
        cycles(1);
        chk("k0_flag_edge8", int'(bus.key_flag), 0);
        chk("k0_wave_edge8", int'(bus.waveform_counter), 1);
        cycles(12);
        bus.key[0] = 1'b1;
        cycles(10);
        for (int i = 0; i < 3; i++) begin
            press(0, 20, 10);
            chk("k0_wave_step", int'(bus.waveform_counter), exp_wave[i]);
        end
        chk("k0_freq_untouched", int'(bus.freq_counter), 0);
        chk("k0_freq2_untouched", int'(bus.freq_counter2), 0);

        // Three-cycle glitch on key[1] must be filtered.
        press(1, 3, 10);
        chk("glitch_freq", int'(bus.freq_counter), 0);
        bus.key[1] = 1'b0;
        cycles(7);
        chk("k1_freq_edge7", int'(bus.freq_counter), 0);
        cycles(1);
        chk("k1_freq_edge8", int'(bus.freq_counter), 1);
        cycles(2);
        bus.key[1] = 1'b1;
        cycles(8);

        for (int i = 0; i < 6; i++) begin
            press(1, 10, 8);
            chk("freq_up", int'(bus.freq_counter), exp_up[i]);
        end
        for (int i = 0; i < 7; i++) begin
            press(2, 10, 8);
            chk("freq_down", int'(bus.freq_counter), exp_dn[i]);
        end

        // Simultaneous key[0..2]: +1 and -1 cancel, waveform still advances.
        press(1, 10, 8);
        press(1, 10, 8);
        chk("pre_sim_freq", int'(bus.freq_counter), 2);
        bus.key = 4'b1000;
        cycles(7);
        chk("sim_flags", int'(bus.key_flag), 7);
        cycles(1);
        chk("sim_freq", int'(bus.freq_counter), 2);
        chk("sim_wave", int'(bus.waveform_counter), 1);
        bus.key = 4'hF;
        cycles(8);

        for (int i = 0; i < 33; i++) begin
            press(3, 10, 8);
            chk("freq2_step", int'(bus.freq_counter2), (i + 1) % 32);
        end

        // Reset in the middle of a key[0] debounce, key still held afterwards.
        bus.key[0] = 1'b0;
        cycles(3);
        #2 sys_rst = 1'b1;
        cycles(2);
        chk("midrst_flag", int'(bus.key_flag), 0);
        chk("midrst_wave", int'(bus.waveform_counter), 0);
        chk("midrst_freq", int'(bus.freq_counter), FREQ_INIT);
        chk("midrst_freq2", int'(bus.freq_counter2), 0);
        sys_rst = 1'b0;
        cycles(CNT_MAX + 3);
        chk("rst_flag_before", int'(bus.key_flag), 0);
        cycles(1);
        chk("rst_flag_pulse", int'(bus.key_flag), 1);
        cycles(1);
        chk("rst_flag_after", int'(bus.key_flag), 0);
        chk("rst_wave", int'(bus.waveform_counter), 1);
        cycles(5);
        bus.key[0] = 1'b1;
        cycles(8);
        chk("rst_wave_final", int'(bus.waveform_counter), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
